// File: rtl/dff_posedge.sv
// dff_posedge: rising-edge D flip-flop bank with async active-high clear and preset, clear wins.
// Define DFF_POSEDGE_ASSERT_EN to compile in simulation-only sanity checks.
module dff_posedge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic             set_c;

  // Preset is masked by clear, so clear falling under a held preset raises set_c and loads all-1.
  assign set_c = preset & ~clear;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk or posedge clear or posedge set_c) begin
    if (clear) begin
      q_q <= '0;
    end else if (set_c) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

`ifdef DFF_POSEDGE_ASSERT_EN
  // Simulation-only checks; they never affect q or qbar.
  always @(posedge clear or posedge preset) begin
    if (clear && preset) begin
      $warning("dff_posedge: clear and preset asserted together");
    end
  end

  always @(negedge clk) begin
    if (qbar !== ~q) begin
      $error("dff_posedge: qbar differs from ~q");
    end
  end

  always @(clk or clear or preset) begin
    if (clear !== 1'b1 && $isunknown({clk, clear, preset})) begin
      $error("dff_posedge: X/Z on clk, clear or preset outside reset");
    end
  end
`else
`endif

endmodule

// File: tb/tb_dff_posedge.sv
// Randomised scoreboard bench for dff_posedge (8-bit and 1-bit instances sharing controls).
module tb_dff_posedge;

  logic       clk;
  logic       clear;
  logic       preset;
  logic [7:0] d;
  logic [7:0] q8;
  logic [7:0] qbar8;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [0:0] qbar1;

  typedef struct {
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  event       sample_ev;
  int         total;
  int         bad;
  logic [7:0] m;

  assign d1 = d[0:0];

  dff_posedge #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clear(clear), .preset(preset), .d(d), .q(q8), .qbar(qbar8)
  );

  dff_posedge #(.WIDTH(1)) u_dut1 (
    .clk(clk), .clear(clear), .preset(preset), .d(d1), .q(q1), .qbar(qbar1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per sample event and compares every output against it.
  initial begin
    forever begin
      exp_t e;
      @(sample_ev);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL empty_scoreboard: sample with no expectation queued");
      end else begin
        e = sb.pop_front();
        total++;
        if (q8 !== e.val) begin
          bad++;
          $display("FAIL %s q8: got %h want %h", e.name, q8, e.val);
        end
        total++;
        if (qbar8 !== ~e.val) begin
          bad++;
          $display("FAIL %s qbar8: got %h want %h", e.name, qbar8, ~e.val);
        end
        total++;
        if (q1 !== e.val[0:0] || qbar1 !== ~e.val[0:0]) begin
          bad++;
          $display("FAIL %s w1: got q=%b qbar=%b want q=%b qbar=%b",
                   e.name, q1, qbar1, e.val[0], ~e.val[0]);
        end
      end
    end
  end

  task automatic chk(input string name);
    exp_t e;
    e.val  = m;
    e.name = name;
    sb.push_back(e);
    ->sample_ev;
    #1;
  endtask

  // Reference: an edge captures d only when neither async input is high.
  task automatic tick(input logic [7:0] v, input string name);
    @(negedge clk);
    d = v;
    @(posedge clk);
    #1;
    if (clear) m = 8'h00;
    else if (preset) m = 8'hFF;
    else m = v;
    chk(name);
  endtask

  // Async inputs change mid-phase, away from any rising edge; effect is immediate.
  task automatic set_async(input logic c, input logic p, input logic hi_phase, input string name);
    if (hi_phase) @(posedge clk);
    else @(negedge clk);
    #2;
    clear  = c;
    preset = p;
    #1;
    if (c) m = 8'h00;
    else if (p) m = 8'hFF;
    chk(name);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    clear  = 1'b1;
    preset = 1'b0;
    d      = 8'h00;
    m      = 8'h00;
    #12;
    chk("reset");

    // Both async inputs high: clear wins regardless of clock and d.
    set_async(1'b1, 1'b1, 1'b0, "both_assert");
    for (int i = 0; i < 3; i++) tick(8'hFF, "both_clocked");

    // Clear drops while preset held: all-1 at once; clock edges ignored.
    set_async(1'b0, 1'b1, 1'b0, "clear_release_under_preset");
    tick(8'h00, "preset_hold_a");
    tick(8'h00, "preset_hold_b");

    // Preset release keeps all-1 until the next rising edge.
    set_async(1'b0, 1'b0, 1'b1, "preset_release_hold");
    tick(8'h00, "capture_zero");
    tick(8'hFF, "capture_ones");

    // Falling edge and d changes in the high phase have no effect.
    @(posedge clk);
    #2;
    d = 8'h00;
    @(negedge clk);
    #1;
    chk("no_fall_capture");

    // Async clear between edges, then hold until a rising edge captures d.
    set_async(1'b1, 1'b0, 1'b1, "async_clear");
    set_async(1'b0, 1'b0, 1'b0, "clear_release_hold");
    tick(8'hFF, "after_clear_capture");

    // Clear released exactly on a rising edge: that edge does not capture.
    set_async(1'b1, 1'b0, 1'b0, "clear_again");
    @(negedge clk);
    d = 8'hFF;
    @(posedge clk);
    clear <= 1'b0;
    #1;
    chk("coincident_release");
    tick(8'hFF, "after_coincident");

    tick(8'hA5, "width_a5");
    set_async(1'b0, 1'b1, 1'b1, "width_preset");
    set_async(1'b0, 1'b0, 1'b0, "width_preset_release");
    tick(8'h3C, "width_3c");

    // Random mix of captures and async pulses.
    for (int i = 0; i < 60; i++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op < 6) begin
        tick(8'($urandom), "rand_tick");
      end else begin
        set_async(1'($urandom), 1'($urandom), 1'($urandom), "rand_async");
        if (clear || preset) tick(8'($urandom), "rand_held_tick");
        set_async(1'b0, 1'b0, 1'($urandom), "rand_release");
      end
    end

    #5;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
